// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID boundary: fetch-side FSM encoding and defaults.
package if_id_stage_pkg;
    localparam int          DATA_W_DEF    = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } if_state_e;
endpackage

// File: rtl/dffare.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module dffare #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Storage: reset wins, then load on enable, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end
endmodule

// File: rtl/if_id_skid.sv
// One-entry holding register for a fetched pc/instr pair that decode could not take yet.
module if_id_skid #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic              o_full,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr
);
    logic w_data_en;
    logic w_full_en;
    logic w_full_d;

    // Clear beats load so a flush always empties the entry.
    assign w_data_en = i_load & ~i_clear;
    assign w_full_en = i_load | i_clear;
    assign w_full_d  = i_load & ~i_clear;

    dffare #(.W(1), .RST_VAL(1'b0)) u_full (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_full_en), .i_d(w_full_d), .o_q(o_full)
    );
    dffare #(.W(DATA_W), .RST_VAL('0)) u_pc (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_data_en), .i_d(i_pc), .o_q(o_pc)
    );
    dffare #(.W(DATA_W), .RST_VAL('0)) u_instr (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_data_en), .i_d(i_instr), .o_q(o_instr)
    );
endmodule

// File: rtl/if_id_stage_chk.sv
// Protocol checker for the instruction-memory handshake and fetch-enable gating.
module if_id_stage_chk
    import if_id_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  if_state_e         i_state,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    input  logic              i_valid,
    input  logic              i_fetch_en,
    input  logic              i_accept,
    input  logic              i_flush
);
    a_addr_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_req && !i_valid && (i_state == ST_BUSY || i_state == ST_DRAIN))
        |=> (i_addr == $past(i_addr)));

    a_no_valid_without_req: assert property (@(posedge i_clk) disable iff (i_rst)
        i_valid |-> i_req);

    a_full_fetch_en: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_state == ST_FULL && i_fetch_en) |-> (i_accept || i_flush));
endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary: issues fetch requests, owns the IF/ID register, absorbs decode stalls and flushes.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pc_if,
    output logic              o_fetch_en,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [DATA_W-1:0] i_imem_rdata,
    input  logic              i_stall_id,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_pc_id,
    output logic [DATA_W-1:0] o_instr_id,
    output logic              o_valid_id
);
    if_state_e         r_state;
    if_state_e         w_state_nxt;
    logic              w_accept;
    logic              w_deliver;
    logic              w_id_en;
    logic              w_id_valid_d;
    logic [DATA_W-1:0] w_id_pc_d;
    logic [DATA_W-1:0] w_id_instr_d;
    logic [DATA_W-1:0] w_cap_pc;
    logic              w_addr_en;
    logic [DATA_W-1:0] w_addr_d;
    logic [DATA_W-1:0] r_addr_q;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_full;
    logic [DATA_W-1:0] w_skid_pc;
    logic [DATA_W-1:0] w_skid_instr;

    assign w_accept = ~i_stall_id | ~o_valid_id;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, memory request, fetch enable and ID/skid load controls.
    always_comb begin
        w_state_nxt  = r_state;
        o_fetch_en   = 1'b0;
        o_imem_req   = 1'b0;
        o_imem_addr  = r_addr_q;
        w_addr_en    = 1'b0;
        w_addr_d     = r_addr_q;
        w_deliver    = 1'b0;
        w_id_pc_d    = o_pc_id;
        w_id_instr_d = NOP_INSTR;
        w_id_valid_d = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_cap_pc     = (r_state == ST_IDLE) ? i_pc_if : r_addr_q;

        case (r_state)
            ST_IDLE: begin
                o_imem_req  = 1'b1;
                o_imem_addr = i_pc_if;
            end
            ST_BUSY, ST_DRAIN: begin
                o_imem_req = 1'b1;
            end
            ST_FULL: begin
                o_imem_req = 1'b0;
            end
            default: begin
                o_imem_req = 1'b0;
            end
        endcase

        if (i_rst) begin
            o_imem_req = 1'b0;
            o_fetch_en = 1'b0;
        end else if (i_flush) begin
            // Redirect: PC takes the new target, ID and skid are squashed.
            o_fetch_en   = 1'b1;
            w_skid_clear = 1'b1;
            case (r_state)
                ST_IDLE, ST_BUSY: begin
                    if (i_imem_valid) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_addr_en   = 1'b1;
                        w_addr_d    = o_imem_addr;
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_FULL:  w_state_nxt = ST_IDLE;
                ST_DRAIN: w_state_nxt = ST_DRAIN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_IDLE, ST_BUSY: begin
                    if (i_imem_valid) begin
                        if (w_accept) begin
                            w_deliver    = 1'b1;
                            w_id_pc_d    = w_cap_pc;
                            w_id_instr_d = i_imem_rdata;
                            w_id_valid_d = 1'b1;
                            o_fetch_en   = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_FULL;
                        end
                    end else if (r_state == ST_IDLE) begin
                        w_addr_en   = 1'b1;
                        w_addr_d    = i_pc_if;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // An empty skid here is unreachable; fall back to IDLE without advancing the PC.
                    if (w_accept && w_skid_full) begin
                        w_deliver    = 1'b1;
                        w_id_pc_d    = w_skid_pc;
                        w_id_instr_d = w_skid_instr;
                        w_id_valid_d = 1'b1;
                        o_fetch_en   = 1'b1;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else if (!w_skid_full) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_DRAIN: begin
                    if (i_imem_valid) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Without a delivery the ID register either bubbles (accept/flush) or holds.
    assign w_id_en = w_deliver | w_accept | i_flush;

    dffare #(.W(1), .RST_VAL(1'b0)) u_valid_id (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_id_en), .i_d(w_id_valid_d), .o_q(o_valid_id)
    );
    dffare #(.W(DATA_W), .RST_VAL(NOP_INSTR)) u_instr_id (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_id_en), .i_d(w_id_instr_d), .o_q(o_instr_id)
    );
    dffare #(.W(DATA_W), .RST_VAL('0)) u_pc_id (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_id_en), .i_d(w_id_pc_d), .o_q(o_pc_id)
    );
    dffare #(.W(DATA_W), .RST_VAL('0)) u_addr_q (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_addr_en), .i_d(w_addr_d), .o_q(r_addr_q)
    );

    if_id_skid #(.DATA_W(DATA_W)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (w_cap_pc),
        .i_instr (i_imem_rdata),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    if_id_stage_chk #(.DATA_W(DATA_W)) u_chk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_state    (r_state),
        .i_req      (o_imem_req),
        .i_addr     (o_imem_addr),
        .i_valid    (i_imem_valid),
        .i_fetch_en (o_fetch_en),
        .i_accept   (w_accept),
        .i_flush    (i_flush)
    );
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Sits between instruction_fetch and decode.
- Issues instruction-memory requests for the current fetch PC over a variable-latency req/valid interface, and owns the IF/ID pipeline register (pc_id, instr_id, valid_id).
- Drives the fetch stage's PC enable, so the PC advances only when an instruction has been accepted or a redirect occurs.
- Absorbs decode stalls with a one-entry skid register and discards stale memory responses after a flush.

Parameters:
- DATA_W, 32, instruction/PC width.
- NOP_INSTR, 32'h0000_0000, value loaded into instr_id on reset/flush/bubble.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_if  in  32  current PC from instruction_fetch
- fetch_en  out  1  enable to instruction_fetch PC register (combinational)
- imem_req  out  1  memory request, level, held until imem_valid
- imem_addr  out  32  request address, stable while imem_req is high
- imem_valid  in  1  response strobe; at most one outstanding request
- imem_rdata  in  32  instruction, valid when imem_valid=1
- stall_id  in  1  decode cannot accept a new instruction this cycle
- flush  in  1  squash ID and in-flight fetch; fetch redirects the same cycle
- pc_id  out  32  PC of instruction in ID
- instr_id  out  32  instruction in ID
- valid_id  out  1  ID holds a real instruction

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, valid_id=0, instr_id=NOP_INSTR, pc_id=0, skid empty, addr_q=0. While rst=1, imem_req=0 and fetch_en=0. Memory is reset by the same rst, so no response survives reset.
- accept = ~stall_id | ~valid_id. A delivery is imem_valid in IDLE or BUSY, or a held skid in FULL.
- FSM states: IDLE, BUSY, FULL, DRAIN.
- IDLE: imem_req=1, imem_addr=pc_if (zero-wait memory may respond the same cycle).
  - imem_valid & accept: load ID (pc_id<=pc_if, instr_id<=imem_rdata, valid_id<=1), fetch_en=1, stay IDLE.
  - imem_valid & ~accept: skid<=(pc_if, imem_rdata), fetch_en=0, go FULL.
  - No imem_valid: addr_q<=pc_if, go BUSY.
- BUSY: imem_req=1, imem_addr=addr_q. imem_valid is handled as in IDLE, but the captured pc is addr_q. Otherwise stay BUSY.
- FULL: imem_req=0.
  - accept: ID<=skid, fetch_en=1, go IDLE.
  - Otherwise hold.
- DRAIN: imem_req=1, imem_addr=addr_q. On imem_valid, drop the data and go IDLE.
- ID register when no delivery this cycle:
  - accept: valid_id<=0, instr_id<=NOP_INSTR (bubble); pc_id holds.
  - ~accept: hold.
- flush has top priority over delivery and stall:
  - fetch_en=1 so the redirect target loads into the PC.
  - valid_id<=0, instr_id<=NOP_INSTR; skid dropped.
  - From IDLE or BUSY without imem_valid: addr_q<=current imem_addr, go DRAIN.
  - From IDLE or BUSY with imem_valid: drop data, go IDLE.
  - From FULL: go IDLE.
  - From DRAIN: stay DRAIN.
- fetch_en is 0 in every case not listed above.
- Throughput: one instruction per cycle with a zero-wait memory and no stalls. An N-cycle memory latency gives one instruction per N+1 cycles.
- Protocol assertions:
  - imem_addr is stable while imem_req is high across cycles in BUSY/DRAIN.
  - No imem_valid while imem_req=0.
  - fetch_en never asserted in FULL without accept or flush.

Decomposition:
- Shared pipeline package: state encoding (IDLE/BUSY/FULL/DRAIN), NOP_INSTR constant, and the DATA_W default.
- Pipeline flops use the codebase's enabled/resettable register primitive (dffare).
- One natural sub-module: if_id_skid, the one-entry pc/instr holding register with its full flag.

Test Plan:
- Zero-wait memory (imem_valid same cycle as req), pc_if 0x00400000 incrementing, no stalls → valid_id=1 from the second cycle after reset, pc_id advancing 0x00400000, 0x00400004, … every cycle; fetch_en=1 continuously.
- 2-cycle-latency memory returning 0x8C080004 for addr 0x00400000 → imem_addr held at 0x00400000 for 3 cycles, then pc_id=0x00400000, instr_id=0x8C080004; bubbles (valid_id=0) in between.
- stall_id=1 for 3 cycles while a response arrives → FULL, imem_req=0, fetch_en=0, ID unchanged. When stall_id drops, the skid instruction moves to ID in 1 cycle with the correct pc, and there are no duplicates or losses.
- flush in BUSY (latency 3) with redirect to 0x00400100 → fetch_en=1, valid_id=0 next cycle, state DRAIN. The stale response is dropped and the next request uses imem_addr=0x00400100.
- flush and imem_valid in the same cycle → data discarded, valid_id=0, state IDLE; also flush in FULL → skid cleared, IDLE.
- rst asserted mid-BUSY → next cycle valid_id=0, instr_id=0, pc_id=0, imem_req=0, fetch_en=0; the first request after rst drops uses pc_if.
